// File: rtl/pdp8_mem_pkg.sv
// Shared types and constants for the 32Kx12 main-memory sequencer/arbiter.
// Holds the default bus widths, the sequencer state encoding and the owner ids.
package pdp8_mem_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational CPU/DMA winner select. Fixed DMA priority by default;
// MEM_ARB_ROUND_ROBIN_EN favours the requester not served last on a tie.
module mem_arb_pick
    import pdp8_mem_pkg::*;
(
    input  logic cpu_elig_i,
    input  logic dma_elig_i,
    input  logic last_i,
    output logic grant_vld_o,
    output logic grant_own_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_vld_o = cpu_elig_i | dma_elig_i;
        if (cpu_elig_i && dma_elig_i) begin
            grant_own_o = (last_i == OWN_DMA) ? OWN_CPU : OWN_DMA;
        end else begin
            grant_own_o = dma_elig_i ? OWN_DMA : OWN_CPU;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        grant_vld_o = cpu_elig_i | dma_elig_i;
        grant_own_o = dma_elig_i ? OWN_DMA : OWN_CPU;
    end
`endif

endmodule

// File: rtl/mem_arbiter_32kx12.sv
// CPU/DMA arbiter and CE_N/WE_N sequencer for the 32Kx12 async RAM; all outputs registered.
// Read ack RD_CYCLES+1 edges after grant, write ack WR_PULSE+3; MEM_ARB_ROUND_ROBIN_EN selects round-robin.
module mem_arbiter_32kx12
    import pdp8_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_CYCLES = 2,
    parameter int WR_PULSE  = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    output logic              ram_ce_n,
    output logic              ram_we_n
);

    localparam int CNT_MAX = (RD_CYCLES > WR_PULSE) ? RD_CYCLES : WR_PULSE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              busy_q, busy_d;

    logic cpu_elig, dma_elig, grant_vld, grant_own, grant_we, complete;

    // No grant at all during an ack cycle: a req still high from the finishing
    // transaction cannot re-grant, and every completion leaves one idle bubble.
    assign cpu_elig = cpu_req & ~cpu_ack_q & ~dma_ack_q;
    assign dma_elig = dma_req & ~dma_ack_q & ~cpu_ack_q;

    mem_arb_pick u_pick (
        .cpu_elig_i  (cpu_elig),
        .dma_elig_i  (dma_elig),
        .last_i      (last_q),
        .grant_vld_o (grant_vld),
        .grant_own_o (grant_own)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        a_d       = a_q;
        di_d      = di_q;
        rdata_d   = rdata_q;
        ce_n_d    = ce_n_q;
        we_n_d    = we_n_q;
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        grant_we  = 1'b0;
        complete  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    owner_d  = grant_own;
                    last_d   = grant_own;
                    ce_n_d   = 1'b0;
                    a_d      = (grant_own == OWN_DMA) ? dma_addr  : cpu_addr;
                    di_d     = (grant_own == OWN_DMA) ? dma_wdata : cpu_wdata;
                    grant_we = (grant_own == OWN_DMA) ? dma_we    : cpu_we;
                    state_d  = grant_we ? ST_WR_SETUP : ST_RD;
                    cnt_d    = CNT_W'(RD_CYCLES - 1);
                end
            end
            ST_RD: begin
                if (cnt_q == '0) begin
                    rdata_d  = ram_do;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                we_n_d  = 1'b0;
                cnt_d   = CNT_W'(WR_PULSE - 1);
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) begin
                    we_n_d  = 1'b1;
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_HOLD: complete = 1'b1;
            default:    state_d = ST_IDLE;
        endcase

        if (complete) begin
            ce_n_d  = 1'b1;
            state_d = ST_IDLE;
            if (owner_q == OWN_DMA) begin
                dma_ack_d = 1'b1;
            end else begin
                cpu_ack_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= OWN_CPU;
            last_q    <= OWN_CPU;
            a_q       <= '0;
            di_q      <= '0;
            rdata_q   <= '0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            a_q       <= a_d;
            di_q      <= di_d;
            rdata_q   <= rdata_d;
            ce_n_q    <= ce_n_d;
            we_n_q    <= we_n_d;
            cpu_ack_q <= cpu_ack_d;
            dma_ack_q <= dma_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign mem_rdata = rdata_q;
    assign busy      = busy_q;
    assign ram_a     = a_q;
    assign ram_di    = di_q;
    assign ram_ce_n  = ce_n_q;
    assign ram_we_n  = we_n_q;

endmodule

// File: doc/mem_arbiter_32kx12.md
Name: mem_arbiter_32kx12

Overview:
Sequencer and two-port arbiter for the 32Kx12 asynchronous static main memory. It shares the RAM between the CPU and the data-break (DMA) channel. It generates registered, glitch-free CE_N/WE_N timing and returns read data through a per-requester ack pulse. It sits between the CPU/DMA logic and the RAM pins.

Parameters:
- ADDR_W, 15, RAM address width (32K words)
- DATA_W, 12, word width
- RD_CYCLES, 2, cycles CE_N is held low before read data is captured (≥1)
- WR_PULSE, 1, cycles WE_N is held low during a write (≥1)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU request; level, held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack  same as CPU set, data-break channel
- mem_rdata  out  DATA_W  last read word; valid while the matching ack is high, held until the next read completes
- busy  out  1  high when not in IDLE
- ram_a  out  ADDR_W  RAM address
- ram_di  out  DATA_W  RAM write data
- ram_do  in  DATA_W  RAM read data (asynchronous)
- ram_ce_n  out  1  RAM chip enable, active-low
- ram_we_n  out  1  RAM write enable, active-low

Behaviour:
- Reset values: state IDLE, ram_ce_n=1, ram_we_n=1, ram_a=0, ram_di=0, mem_rdata=0, cpu_ack=dma_ack=0, busy=0.
- All outputs are registered; no combinational path from any input to an output.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE arbitration:
  - A requester is eligible if its req=1 and its ack is not high this cycle. This prevents a duplicate transaction from a req still high during its ack cycle.
  - Winner: DMA over CPU (fixed priority).
  - On grant, latch addr, wdata and we into ram_a/ram_di and the owner register, and drive ram_ce_n=0.
  - Next state is RD if we=0, else WR_SETUP.
- RD:
  - Stays for RD_CYCLES cycles, ram_we_n=1.
  - On the final edge, capture ram_do into mem_rdata, set owner ack=1, ram_ce_n=1, and go to IDLE.
  - Read ack is high in the cycle after edge RD_CYCLES, counting the grant edge as edge 0.
- Write sequence:
  - WR_SETUP: 1 cycle, ce low, we high, address and data valid.
  - WR_PULSE: WR_PULSE cycles with ram_we_n=0.
  - WR_HOLD: 1 cycle, we high, address and data still held.
  - Then go to IDLE with owner ack=1 and ram_ce_n=1.
  - Write ack is high after edge WR_PULSE+2.
- ram_a and ram_di are never changed while ram_ce_n=0. ram_we_n never falls in the same cycle that ram_a changes.
- Ack: exactly one cycle and only to the owner. cpu_ack and dma_ack are never high together.
- Back-to-back: a requester holding req gets its next grant one cycle after its ack (one idle bubble minimum).
- Request dropped mid-transaction: the latched transaction completes and the ack still pulses; the requester ignores it.
- Request changes (addr/we/wdata) mid-transaction: ignored until the next grant.
- Reset mid-transaction: on the reset edge all outputs return to reset values. ram_we_n=1 takes effect immediately, with no partial-pulse stretch. No ack is issued for the aborted transaction.
- mem_rdata is not modified by writes.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- When defined: a last-served bit (reset to CPU) is kept. On simultaneous eligible requests, the requester not last served wins, and the bit updates on each grant.
- When undefined: fixed DMA priority as above. CPU can starve under continuous DMA traffic, which is accepted.

Decomposition:
- Package pdp8_mem_pkg holds:
  - ADDR_W and DATA_W defaults
  - state encoding (IDLE/RD/WR_SETUP/WR_PULSE/WR_HOLD)
  - owner id constants OWN_CPU=0, OWN_DMA=1
- Sub-module mem_arb_pick: combinational winner select from the two eligible bits plus the last-served bit. It contains the fixed-priority and round-robin variants under the macro.

Test Plan:
- Reset, then CPU read of addr 00100 holding 7421 (RD_CYCLES=2): cpu_ack high one cycle after edge 2, mem_rdata=7421, ram_ce_n low for exactly 2 cycles, ram_we_n stays 1.
- CPU write 5252 to 17777 (WR_PULSE=1): ram_we_n low exactly 1 cycle, ram_a/ram_di stable from setup through hold, cpu_ack after edge 3; a following read of 17777 returns 5252.
- CPU and DMA both request at the same edge (DMA read 00200, CPU write 00200←1234): DMA is served first and gets the old value; CPU is granted the cycle after dma_ack; acks never overlap.
- CPU holds cpu_req for 3 reads: exactly 3 acks, each separated by one idle cycle, with no duplicate grant during any ack cycle.
- Reset asserted during WR_PULSE: next cycle ram_we_n=1, ram_ce_n=1, busy=0, no ack; the RAM word is not guaranteed, but the controller accepts a new request after reset deasserts.
- With MEM_ARB_ROUND_ROBIN_EN, both reqs held continuously for 4 transactions: grants alternate DMA, CPU, DMA, CPU. Without the macro: all 4 go to DMA.
